// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES field arithmetic, S-boxes and inverse-round helpers
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_KEXP,
      ST_DEC
   } dec_state_t;

   localparam int NW = 52;
   localparam logic [5:0] LAST_W = 6'd51;
   localparam logic [7:0] RCON [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                       8'h10, 8'h20, 8'h40, 8'h80};

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // General GF(2^8) product; the fixed x9/x11/x13/x14 multiplies use it.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] y;
      r = 8'h01;
      y = a;
      for (int i = 1; i < 8; i++) begin
         y = gmul(y, y);
         r = gmul(r, y);
      end
      return r;
   endfunction

   // S-box derived from the field inverse and affine map instead of a table.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] b;
      b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
      return r;
   endfunction

   // Byte n sits at s[127-8n -: 8], column n/4, row n%4; row r rotates right by r.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] res;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      return res;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] res;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         res[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         res[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         res[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         res[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return res;
   endfunction

endpackage

// File: rtl/aes_192_inv_round.sv
// rtl/aes_192_inv_round.sv - one combinational AES inverse round
module aes_192_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] round_key,
   input  logic         last,
   output logic [127:0] next_state
);

   logic [127:0] added;

   // The final round skips InvMixColumns.
   assign added      = inv_sub_bytes(inv_shift_rows(state)) ^ round_key;
   assign next_state = last ? added : inv_mix_columns(added);

endmodule

// File: rtl/aes_192_dec.sv
// rtl/aes_192_dec.sv - iterative AES-192 decryptor with scan chain on state_r
module aes_192_dec
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         scan_input,
   output logic         scan_output,
   input  logic         scan_enable,
   input  logic         scan_ck_en,
   input  logic         start,
   input  logic [127:0] state,
   input  logic [191:0] key,
   output logic [127:0] out,
   output logic         out_valid,
   output logic         busy
);

   dec_state_t   fsm;
   logic         start_r;
   logic [127:0] state_r;
   logic [5:0]   widx;
   logic [3:0]   rnd;
   logic [31:0]  w [NW];

   logic         accept;
   logic [5:0]   wdiv;
   logic [31:0]  w_prev;
   logic [31:0]  w_old;
   logic [31:0]  w_new;
   logic [5:0]   rk_base;
   logic [127:0] rk;
   logic [127:0] round_out;

   assign accept      = ~scan_enable & start & ~start_r & (fsm == ST_IDLE);
   assign scan_output = state_r[127];

   // Next schedule word; every sixth word takes the RotWord/SubWord/rcon path.
   always_comb begin
      w_prev = w[widx - 6'd1];
      w_old  = w[widx - 6'd6];
      wdiv   = widx / 6'd6;
      w_new  = w_old ^ w_prev;
      if (widx == wdiv * 6'd6)
         w_new = w_old ^ sub_word(rot_word(w_prev)) ^ {RCON[wdiv[2:0] - 3'd1], 24'h0};
   end

   // Round key rk[rnd] is four consecutive schedule words.
   always_comb begin
      rk_base = {rnd, 2'b00};
      rk      = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
   end

   aes_192_inv_round u_round (
      .state      (state_r),
      .round_key  (rk),
      .last       (rnd == 4'd0),
      .next_state (round_out)
   );

   // Schedule storage: loaded on accept, extended one word per KEXP cycle, frozen in scan.
   always_ff @(posedge clk) begin
      if (!scan_enable) begin
         if (accept) begin
            w[0] <= key[191:160];
            w[1] <= key[159:128];
            w[2] <= key[127:96];
            w[3] <= key[95:64];
            w[4] <= key[63:32];
            w[5] <= key[31:0];
         end else if (fsm == ST_KEXP) begin
            w[widx] <= w_new;
         end
      end
   end

   // Control FSM, counters, state register and scan shifting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= ST_IDLE;
         out       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         start_r   <= 1'b0;
         state_r   <= '0;
         widx      <= '0;
         rnd       <= '0;
      end else if (scan_enable) begin
         if (scan_ck_en) state_r <= {state_r[126:0], scan_input};
      end else begin
         start_r <= start;
         case (fsm)
            ST_IDLE: begin
               if (accept) begin
                  state_r   <= state;
                  out_valid <= 1'b0;
                  busy      <= 1'b1;
                  widx      <= 6'd6;
                  fsm       <= ST_KEXP;
               end
            end
            ST_KEXP: begin
               widx <= widx + 6'd1;
               if (widx == LAST_W) begin
                  rnd <= 4'd12;
                  fsm <= ST_DEC;
               end
            end
            ST_DEC: begin
               if (rnd == 4'd12) begin
                  state_r <= state_r ^ rk;
                  rnd     <= rnd - 4'd1;
               end else if (rnd != 4'd0) begin
                  state_r <= round_out;
                  rnd     <= rnd - 4'd1;
               end else begin
                  out       <= round_out;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  fsm       <= ST_IDLE;
               end
            end
            default: fsm <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_192_dec.sv
// tb/tb_aes_192_dec.sv - directed self-checking bench for aes_192_dec
module tb_aes_192_dec;

   localparam logic [191:0] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] PT_C2  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_Z   = 128'haae06992acbf52a3e8f4a96ec9300bd7;
   localparam logic [127:0] SCAN_P = 128'hb4c3d2e1f00f1e2d3c4b5a6978695a4b;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         scan_input;
   logic         scan_output;
   logic         scan_enable;
   logic         scan_ck_en;
   logic         start;
   logic [127:0] ct;
   logic [191:0] key;
   logic [127:0] dout;
   logic         out_valid;
   logic         busy;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   always #5 clk = ~clk;

   aes_192_dec dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .scan_input  (scan_input),
      .scan_output (scan_output),
      .scan_enable (scan_enable),
      .scan_ck_en  (scan_ck_en),
      .start       (start),
      .state       (ct),
      .key         (key),
      .out         (dout),
      .out_valid   (out_valid),
      .busy        (busy)
   );

   // Returns at the falling edge right after the accept edge T.
   task automatic pulse_start(input logic [191:0] k, input logic [127:0] c);
      @(negedge clk);
      key   = k;
      ct    = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_cnt++; if (dout !== 128'h0) $display("FAIL reset_out: got %h expected 0", dout); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
      chk_cnt++; if (scan_output !== 1'b0) $display("FAIL reset_scan_out: got %b expected 0", scan_output); else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_c2_repulse;
      pulse_start(KEY_C2, CT_C2);
      chk_cnt++; if (busy !== 1'b1) $display("FAIL c2_busy_t1: got %b expected 1", busy); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (dut.w[6] !== 32'h5846f2f9) $display("FAIL c2_w6: got %h expected 5846f2f9", dut.w[6]); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (dut.w[7] !== 32'h5c43f4fe) $display("FAIL c2_w7: got %h expected 5c43f4fe", dut.w[7]); else pass_cnt++;
      repeat (7) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (36) @(negedge clk);
      chk_cnt++; if ({dut.w[48], dut.w[49], dut.w[50], dut.w[51]} !== 128'ha4970a331a78dc09c418c271e3a41d5d)
         $display("FAIL c2_rk12: got %h%h%h%h expected a4970a331a78dc09c418c271e3a41d5d",
                  dut.w[48], dut.w[49], dut.w[50], dut.w[51]);
      else pass_cnt++;
      repeat (12) @(negedge clk);
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL c2_valid_t58: got %b expected 0", out_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL c2_busy_t58: got %b expected 1", busy); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL c2_valid_t59: got %b expected 1", out_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL c2_busy_t59: got %b expected 0", busy); else pass_cnt++;
      chk_cnt++; if (dout !== PT_C2) $display("FAIL c2_out: got %h expected %h", dout, PT_C2); else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      key   = '0;
      ct    = CT_Z;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_valid_clear: got %b expected 0", out_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b expected 1", busy); else pass_cnt++;
      repeat (58) @(negedge clk);
      chk_cnt++; if (dout !== PT_C2) $display("FAIL b2b_out_hold: got %h expected %h", dout, PT_C2); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_valid_t58: got %b expected 0", out_valid); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid_t59: got %b expected 1", out_valid); else pass_cnt++;
      chk_cnt++; if (dout !== 128'h0) $display("FAIL b2b_out: got %h expected 0", dout); else pass_cnt++;
   endtask

   task automatic test_scan_midop;
      logic [127:0] cap;
      logic         b;
      cap = '0;
      pulse_start(KEY_C2, CT_C2);
      repeat (49) @(negedge clk);
      scan_enable = 1'b1;
      scan_ck_en  = 1'b1;
      for (int i = 0; i < 128; i++) begin
         b          = scan_output;
         cap        = {cap[126:0], b};
         scan_input = b;
         @(negedge clk);
      end
      chk_cnt++; if (busy !== 1'b1) $display("FAIL scan_busy_frozen: got %b expected 1", busy); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL scan_valid_frozen: got %b expected 0", out_valid); else pass_cnt++;
      chk_cnt++; if (dout !== 128'h0) $display("FAIL scan_out_hold: got %h expected 0", dout); else pass_cnt++;
      scan_enable = 1'b0;
      scan_ck_en  = 1'b0;
      scan_input  = 1'b0;
      repeat (9) @(negedge clk);
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL scan_valid_t186: got %b expected 0", out_valid); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL scan_valid_t187: got %b expected 1", out_valid); else pass_cnt++;
      chk_cnt++; if (dout !== PT_C2) $display("FAIL scan_out: got %h expected %h (captured %h)", dout, PT_C2, cap); else pass_cnt++;
   endtask

   task automatic test_abort;
      pulse_start(KEY_C2, CT_C2);
      repeat (29) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_cnt++; if (dout !== 128'h0) $display("FAIL abort_out: got %h expected 0", dout); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL abort_valid: got %b expected 0", out_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulse_start(KEY_C2, CT_C2);
      repeat (58) @(negedge clk);
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL abort_rerun_valid_t58: got %b expected 0", out_valid); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL abort_rerun_valid_t59: got %b expected 1", out_valid); else pass_cnt++;
      chk_cnt++; if (dout !== PT_C2) $display("FAIL abort_rerun_out: got %h expected %h", dout, PT_C2); else pass_cnt++;
   endtask

   task automatic test_scan_order;
      logic [127:0] pv;
      logic [127:0] cap;
      pv  = SCAN_P;
      cap = '0;
      @(negedge clk);
      scan_enable = 1'b1;
      scan_ck_en  = 1'b1;
      for (int i = 0; i < 128; i++) begin
         scan_input = pv[127-i];
         @(negedge clk);
      end
      scan_ck_en = 1'b0;
      scan_input = 1'b0;
      @(negedge clk);
      chk_cnt++; if (scan_output !== pv[127]) $display("FAIL scan_ck_hold: got %b expected %b", scan_output, pv[127]); else pass_cnt++;
      scan_ck_en = 1'b1;
      for (int i = 0; i < 128; i++) begin
         cap = {cap[126:0], scan_output};
         @(negedge clk);
      end
      chk_cnt++; if (cap !== SCAN_P) $display("FAIL scan_order: got %h expected %h", cap, SCAN_P); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL scan_idle_valid: got %b expected 1", out_valid); else pass_cnt++;
      chk_cnt++; if (dout !== PT_C2) $display("FAIL scan_idle_out: got %h expected %h", dout, PT_C2); else pass_cnt++;
      scan_enable = 1'b0;
      scan_ck_en  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n       = 1'b0;
      scan_input  = 1'b0;
      scan_enable = 1'b0;
      scan_ck_en  = 1'b0;
      start       = 1'b0;
      ct          = '0;
      key         = '0;
      test_reset();
      test_c2_repulse();
      test_back_to_back();
      test_scan_midop();
      test_abort();
      test_scan_order();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
